// File: rtl/operand_normalizer.sv
// Leading-one normalizer for the two 16-bit multiplier operands: each operand is shifted left
// until its MSB is set, yielding an 8-bit mantissa and a shift count per operand.
module operand_normalizer #(
    parameter int DATA_W = 16,
    parameter int MANT_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              ld_a,
    input  logic              ld_b,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [MANT_W-1:0] mant_a,
    output logic [MANT_W-1:0] mant_b,
    output logic [CNT_W-1:0]  sh_a,
    output logic [CNT_W-1:0]  sh_b,
    output logic              zero_a,
    output logic              zero_b
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] ld_vec;
    logic [1:0] need_shift;
    logic       in_idle;
    logic       in_norm;

    assign ld_vec  = {ld_b, ld_a};
    assign in_idle = (state_q == IDLE);
    assign in_norm = (state_q == NORM);

    // Lane 0 is operand A, lane 1 is operand B; both lanes step in lockstep.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_lane
        logic [DATA_W-1:0] op_q;
        logic [DATA_W-1:0] op_d;
        logic [CNT_W-1:0]  sh_q;
        logic [CNT_W-1:0]  sh_d;

        // A zero operand never shifts, which also keeps the count from ever wrapping.
        assign need_shift[gi] = (op_q != '0) && !op_q[DATA_W-1];

        always_comb begin
            op_d = op_q;
            sh_d = sh_q;
            if (in_idle && ld_vec[gi]) begin
                op_d = din;
                sh_d = '0;
            end else if (in_norm && need_shift[gi]) begin
                op_d = op_q << 1;
                sh_d = sh_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                op_q <= '0;
                sh_q <= '0;
            end else begin
                op_q <= op_d;
                sh_q <= sh_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                // A load in the same cycle takes priority and start is dropped.
                if (start && !ld_a && !ld_b) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                busy = 1'b1;
                if (need_shift == 2'b00) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign mant_a = gen_lane[0].op_q[DATA_W-1 -: MANT_W];
    assign mant_b = gen_lane[1].op_q[DATA_W-1 -: MANT_W];
    assign sh_a   = gen_lane[0].sh_q;
    assign sh_b   = gen_lane[1].sh_q;
    assign zero_a = (gen_lane[0].op_q == '0);
    assign zero_b = (gen_lane[1].op_q == '0);

endmodule
